fpu_issue_queue: RTL
====================

Name: fpu_issue_queue

Overview:
- Operand/opcode queue that sits directly upstream of the FPU and feeds its enable/instruction/ai/bi interface.
- Accepts FP operations over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one operation at a time, holding the operands stable until the FPU's valid.
- Returns each result with its caller tag over a second valid/ready handshake.
- A watchdog turns a hung FPU into a flagged qNaN result.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
TAG_W, 4, width of caller tag carried alongside each op
TIMEOUT_CYC, 64, max cycles in WAIT before forced completion

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  op request present
in_ready  out  1  queue can accept (count < DEPTH)
in_op  in  2  FPU instruction code, passed through unchanged
in_a  in  32  operand A (IEEE-754 single)
in_b  in  32  operand B
in_tag  in  TAG_W  caller tag
fpu_enable  out  1  one-cycle start pulse to FPU
fpu_instruction  out  2  opcode to FPU
fpu_ai  out  32  operand A to FPU
fpu_bi  out  32  operand B to FPU
fpu_co  in  32  FPU result
fpu_valid  in  1  FPU result valid
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  32  result word
out_tag  out  TAG_W  tag of the completed op
out_timeout  out  1  result was forced by the watchdog
busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset (clk edge with rst=1):
  - FIFO flushed, count=0, state=IDLE, watchdog=0.
  - All outputs 0 except in_ready=1.
  - An op in flight is dropped; the FPU shares rst.
- Push occurs when in_valid && in_ready at an edge. in_ready is combinational from the registered count: count<DEPTH.
- Push and pop on the same edge are legal; count is unchanged.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If FIFO non-empty, the next state is ISSUE and the head is popped into the issue register (op, a, b, tag) on that edge.
  - A push into an empty queue at edge t gives fpu_enable high in the cycle after edge t+1 (one bubble).
- ISSUE:
  - fpu_enable=1 for exactly this cycle.
  - Next state is WAIT, with watchdog cleared.
  - fpu_valid is ignored in this cycle.
- WAIT:
  - fpu_enable=0.
  - fpu_instruction/fpu_ai/fpu_bi are held from the issue register, as they are in every state from ISSUE until HOLD exits.
  - On fpu_valid=1 at an edge: out_result<=fpu_co, out_tag<=issue tag, out_timeout<=0, next state HOLD.
  - Otherwise the watchdog increments. When watchdog==TIMEOUT_CYC-1 without fpu_valid: out_result<=32'h7FC00000, out_timeout<=1, next state HOLD.
  - If fpu_valid and the timeout coincide on the same edge, fpu_valid wins.
- HOLD:
  - out_valid=1; out_result, out_tag and out_timeout are stable.
  - When out_ready=1 at an edge, next state is IDLE.
  - No new issue occurs while a result is unaccepted, so backpressure stalls issue.
- fpu_valid in IDLE, ISSUE or HOLD is ignored; a late FPU valid after a timeout is discarded.
- Pushes continue to be accepted in all states while count<DEPTH.
- Ordering: results are returned strictly in push order.
- fpu_ai/fpu_bi/fpu_instruction are 0 after reset until the first ISSUE, then retain the last issued values.

Decomposition:
- Shared package fpu_pkg:
  - opcode localparams FPU_ADD=2'b00, FPU_SUB=2'b01, FPU_MUL=2'b10, FPU_RSV=2'b11
  - QNAN_32=32'h7FC00000
  - FSM state enum iq_state_t
- One sub-module, fpu_op_fifo:
  - parameterised DEPTH and WIDTH=2+32+32+TAG_W
  - push/pop/full/empty/count
  - first-word-fall-through head
- The FSM, watchdog and issue/result registers live in fpu_issue_queue.

Test Plan:
1. Single add: push op=00, a=3F800000, b=40000000, tag=3; FPU stub returns 40400000 after 5 cycles.
   - Expect one fpu_enable pulse, with ai/bi held through WAIT.
   - Expect out_valid, out_result=40400000, out_tag=3, out_timeout=0.
2. Fill and backpressure: push 5 ops (tags 0-4) with out_ready=0 and the FPU stub slow.
   - in_ready drops after count reaches 4.
   - Results emerge in tag order 0,1,2,3,4 once out_ready=1.
   - Exactly 5 enable pulses.
3. Push/pop same edge at full: with count=4 and IDLE popping while in_valid=1, the push is refused (in_ready=0). The next cycle the push is accepted and count returns to 4.
4. Watchdog: FPU stub never asserts valid.
   - After TIMEOUT_CYC cycles in WAIT: out_result=7FC00000, out_timeout=1.
   - A stub valid injected 3 cycles later does not produce a second result.
5. Spurious valid: fpu_valid pulsed during IDLE and during the ISSUE cycle of a mul (a=40000000, b=40400000).
   - No result is produced early.
   - Result 40C00000 arrives only on the WAIT-phase valid.
6. Reset mid-operation: assert rst for 1 cycle while in WAIT with 2 queued ops.
   - Afterwards busy=0, out_valid=0, in_ready=1, fpu_enable=0.
   - No stale result appears.
   - A new push issues normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared opcodes, constants and FSM state for the FPU issue queue.
package fpu_pkg;

    localparam logic [1:0] FPU_ADD = 2'b00;
    localparam logic [1:0] FPU_SUB = 2'b01;
    localparam logic [1:0] FPU_MUL = 2'b10;
    localparam logic [1:0] FPU_RSV = 2'b11;

    localparam logic [31:0] QNAN_32 = 32'h7FC00000;

    typedef enum logic [1:0] {
        IQ_IDLE,
        IQ_ISSUE,
        IQ_WAIT,
        IQ_HOLD
    } iq_state_t;

endpackage

// File: rtl/fpu_issue_queue_if.sv
// Request, FPU-side and result signals of the FPU issue queue.
interface fpu_issue_queue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic             fpu_enable;
    logic [1:0]       fpu_instruction;
    logic [31:0]      fpu_ai;
    logic [31:0]      fpu_bi;
    logic [31:0]      fpu_co;
    logic             fpu_valid;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_timeout;
    logic             busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        input  fpu_co, fpu_valid, out_ready,
        output in_ready, fpu_enable, fpu_instruction,
        output fpu_ai, fpu_bi, out_valid, out_result,
        output out_tag, out_timeout, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        output fpu_co, fpu_valid, out_ready,
        input  in_ready, fpu_enable, fpu_instruction,
        input  fpu_ai, fpu_bi, out_valid, out_result,
        input  out_tag, out_timeout, busy
    );

endinterface

// File: rtl/fpu_op_fifo.sv
// First-word-fall-through FIFO holding queued FPU operations.
module fpu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CAP;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers are exactly log2(DEPTH) bits and wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// Buffers FP ops, issues them one at a time to the FPU, returns tagged results.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input logic               clk,
    input logic               rst,
    fpu_issue_queue_if.slave  io
);
    localparam int AW   = $clog2(DEPTH);
    localparam int W    = 2 + 32 + 32 + TAG_W;
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    iq_state_t        state_q;
    iq_state_t        state_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [AW:0]      fifo_cnt;
    logic [W-1:0]     din;
    logic [W-1:0]     head;
    logic [1:0]       head_op;
    logic [31:0]      head_a;
    logic [31:0]      head_b;
    logic [TAG_W-1:0] head_tag;

    logic [1:0]       iss_op;
    logic [31:0]      iss_a;
    logic [31:0]      iss_b;
    logic [TAG_W-1:0] iss_tag;
    logic [WD_W-1:0]  wd_q;
    logic [31:0]      res_q;
    logic [TAG_W-1:0] tag_q;
    logic             to_q;

    logic             wd_clr;
    logic             wd_inc;
    logic             cap_valid;
    logic             cap_to;

    assign push = io.in_valid && !full;
    assign din  = {io.in_op, io.in_a, io.in_b, io.in_tag};
    assign {head_op, head_a, head_b, head_tag} = head;

    fpu_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IQ_IDLE;
        else     state_q <= state_d;
    end

    // A real fpu_valid takes priority over the watchdog on the same edge.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        cap_valid = 1'b0;
        cap_to    = 1'b0;
        unique case (state_q)
            IQ_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = IQ_ISSUE;
                end
            end
            IQ_ISSUE: begin
                wd_clr  = 1'b1;
                state_d = IQ_WAIT;
            end
            IQ_WAIT: begin
                if (io.fpu_valid) begin
                    cap_valid = 1'b1;
                    state_d   = IQ_HOLD;
                end else if (wd_q == WD_LAST) begin
                    cap_to  = 1'b1;
                    state_d = IQ_HOLD;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            IQ_HOLD: begin
                if (io.out_ready) state_d = IQ_IDLE;
            end
            default: state_d = IQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_op  <= '0;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_tag <= '0;
            wd_q    <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            if (pop) begin
                iss_op  <= head_op;
                iss_a   <= head_a;
                iss_b   <= head_b;
                iss_tag <= head_tag;
            end
            if (wd_clr)      wd_q <= '0;
            else if (wd_inc) wd_q <= wd_q + 1'b1;
            if (cap_valid) begin
                res_q <= io.fpu_co;
                tag_q <= iss_tag;
                to_q  <= 1'b0;
            end else if (cap_to) begin
                res_q <= QNAN_32;
                tag_q <= iss_tag;
                to_q  <= 1'b1;
            end
        end
    end

    assign io.in_ready        = !full;
    assign io.fpu_enable      = state_q == IQ_ISSUE;
    assign io.fpu_instruction = iss_op;
    assign io.fpu_ai          = iss_a;
    assign io.fpu_bi          = iss_b;
    assign io.out_valid       = state_q == IQ_HOLD;
    assign io.out_result      = res_q;
    assign io.out_tag         = tag_q;
    assign io.out_timeout     = to_q;
    assign io.busy            = (fifo_cnt != '0) || (state_q != IQ_IDLE);

endmodule
